// File: rtl/pulse_data_sync_s2f_if.sv
// Bus bundle for the slow->fast pulse synchronizer: source event/payload in,
// busy/drop status back to the source, delivered pulse/payload on the fast side.
interface pulse_data_sync_s2f_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
);
  logic              pulse_slow;
  logic [DATA_W-1:0] data_slow;
  logic              busy_slow;
  logic [CNT_W-1:0]  drop_cnt_slow;
  logic              pulse_fast;
  logic [DATA_W-1:0] data_fast;

  modport master (
    output pulse_slow, data_slow,
    input  busy_slow, drop_cnt_slow, pulse_fast, data_fast
  );

  modport slave (
    input  pulse_slow, data_slow,
    output busy_slow, drop_cnt_slow, pulse_fast, data_fast
  );
endinterface

// File: rtl/pulse_data_sync_s2f.sv
// Slow->fast event pulse synchronizer with payload, using a 2-phase toggle req/ack
// handshake; events arriving while a transfer is in flight are dropped and counted.
module pulse_data_sync_s2f #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                  clk_fast,
  input  logic                  rstn,
  input  logic                  clk_slow,
  pulse_data_sync_s2f_if.slave  bus
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  // Source domain state
  state_e                  r_state_s;
  state_e                  w_state_nxt_s;
  logic                    r_req_tgl_s;
  logic [DATA_W-1:0]       r_data_hold_s;
  logic [CNT_W-1:0]        r_drop_cnt_s;
  logic [SYNC_STAGES-1:0]  r_ack_sync_s;
  logic                    w_ack_s;
  logic                    w_accept_s;
  logic                    w_drop_s;

  // Destination domain state
  logic [SYNC_STAGES-1:0]  r_req_sync_f;
  logic                    r_req_seen_f;
  logic                    r_ack_tgl_f;
  logic                    r_pulse_f;
  logic [DATA_W-1:0]       r_data_f;
  logic                    w_req_f;
  logic                    w_detect_f;

  assign w_ack_s = r_ack_sync_s[SYNC_STAGES-1];

  always_ff @(posedge clk_slow or negedge rstn) begin
    if (!rstn) r_state_s <= S_IDLE;
    else       r_state_s <= w_state_nxt_s;
  end

  // Busy is released once the fast side has echoed the current request toggle
  always_comb begin
    w_state_nxt_s = r_state_s;
    case (r_state_s)
      S_IDLE:  if (bus.pulse_slow)             w_state_nxt_s = S_BUSY;
      S_BUSY:  if (w_ack_s == r_req_tgl_s)     w_state_nxt_s = S_IDLE;
      default:                                 w_state_nxt_s = S_IDLE;
    endcase
  end

  always_comb begin
    w_accept_s = 1'b0;
    w_drop_s   = 1'b0;
    case (r_state_s)
      S_IDLE:  w_accept_s = bus.pulse_slow;
      S_BUSY:  w_drop_s   = bus.pulse_slow;
      default: w_accept_s = 1'b0;
    endcase
  end

  // Payload is captured only on accept, so it is frozen for the whole crossing
  always_ff @(posedge clk_slow or negedge rstn) begin
    if (!rstn) begin
      r_req_tgl_s   <= 1'b0;
      r_data_hold_s <= '0;
      r_drop_cnt_s  <= '0;
      r_ack_sync_s  <= '0;
    end else begin
      r_ack_sync_s <= {r_ack_sync_s[SYNC_STAGES-2:0], r_ack_tgl_f};
      if (w_accept_s) begin
        r_data_hold_s <= bus.data_slow;
        r_req_tgl_s   <= ~r_req_tgl_s;
      end
      if (w_drop_s && (r_drop_cnt_s != {CNT_W{1'b1}})) begin
        r_drop_cnt_s <= r_drop_cnt_s + CNT_W'(1);
      end
    end
  end

  assign bus.busy_slow     = (r_state_s == S_BUSY);
  assign bus.drop_cnt_slow = r_drop_cnt_s;

  assign w_req_f    = r_req_sync_f[SYNC_STAGES-1];
  assign w_detect_f = w_req_f ^ r_req_seen_f;

  // Each toggle edge of the synchronized request yields exactly one pulse
  always_ff @(posedge clk_fast or negedge rstn) begin
    if (!rstn) begin
      r_req_sync_f <= '0;
      r_req_seen_f <= 1'b0;
      r_ack_tgl_f  <= 1'b0;
      r_pulse_f    <= 1'b0;
      r_data_f     <= '0;
    end else begin
      r_req_sync_f <= {r_req_sync_f[SYNC_STAGES-2:0], r_req_tgl_s};
      r_pulse_f    <= w_detect_f;
      if (w_detect_f) begin
        r_data_f     <= r_data_hold_s;
        r_ack_tgl_f  <= w_req_f;
        r_req_seen_f <= w_req_f;
      end
    end
  end

  assign bus.pulse_fast = r_pulse_f;
  assign bus.data_fast  = r_data_f;

endmodule
